line_raster: RTL and testbench

LINE_RASTER -- requirements
Module: line_raster

---
 rtl/gpu_pkg.sv | 19 +
 rtl/fb_addr_gen.sv | 21 ++
 rtl/line_raster.sv | 206 ++++++++++++++++++++
 tb/tb_line_raster.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/gpu_pkg.sv
// Purpose: shared defaults and FSM state encoding for the line rasteriser.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package gpu_pkg;

    localparam int COORD_W_DEF   = 10;
    localparam int FB_WIDTH_DEF  = 640;
    localparam int FB_HEIGHT_DEF = 400;
    localparam int ADDR_W_DEF    = 18;
    localparam int COLOR_W_DEF   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SETUP = 2'd1,
        ST_DRAW  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

endpackage

// File: rtl/fb_addr_gen.sv
// Purpose: linear framebuffer address, y*FB_WIDTH + x, wrapped to ADDR_W bits.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module fb_addr_gen
    import gpu_pkg::*;
#(
    parameter int COORD_W  = COORD_W_DEF,
    parameter int FB_WIDTH = FB_WIDTH_DEF,
    parameter int ADDR_W   = ADDR_W_DEF
) (
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic [ADDR_W-1:0]  addr_o
);

    // Modular arithmetic in ADDR_W bits gives the truncated address directly.
    always_comb begin
        addr_o = ADDR_W'(y_i) * ADDR_W'(FB_WIDTH) + ADDR_W'(x_i);
    end

endmodule

// File: rtl/line_raster.sv
// Purpose: Bresenham line rasteriser writing one pixel per cycle into SRAM.
// Latency: first write strobe 3 edges after command accept; one pixel per DRAW cycle.
// Backpressure: one command at a time (ready only in IDLE); I_VIDEO_ON stalls drawing.
module line_raster
    import gpu_pkg::*;
#(
    parameter int COORD_W   = COORD_W_DEF,
    parameter int FB_WIDTH  = FB_WIDTH_DEF,
    parameter int FB_HEIGHT = FB_HEIGHT_DEF,
    parameter int ADDR_W    = ADDR_W_DEF,
    parameter int COLOR_W   = COLOR_W_DEF
) (
    input  logic               I_CLK,
    input  logic               I_RST,
    input  logic               I_CMD_VALID,
    output logic               O_CMD_READY,
    input  logic [COORD_W-1:0] I_X0,
    input  logic [COORD_W-1:0] I_Y0,
    input  logic [COORD_W-1:0] I_X1,
    input  logic [COORD_W-1:0] I_Y1,
    input  logic [COLOR_W-1:0] I_COLOR,
    input  logic               I_VIDEO_ON,
    output logic [ADDR_W-1:0]  O_GPU_ADDR,
    output logic [COLOR_W-1:0] O_GPU_DATA,
    output logic               O_GPU_WRITE,
    output logic               O_GPU_READ,
    output logic               O_BUSY,
    output logic               O_DONE
);

    // Error term needs sign plus one guard bit over the coordinate range.
    localparam int EW = COORD_W + 2;
    localparam logic [COORD_W:0] FBW_C = (COORD_W + 1)'(FB_WIDTH);
    localparam logic [COORD_W:0] FBH_C = (COORD_W + 1)'(FB_HEIGHT);

    state_t state_q, state_d;

    logic [COORD_W-1:0] x0_q, y0_q, x1_q, y1_q;
    logic [COLOR_W-1:0] color_q;

    logic [COORD_W-1:0]   cx_q, cx_d, cy_q, cy_d;
    logic signed [EW-1:0] err_q, err_d;
    logic signed [EW-1:0] dx_q, dx_d, dy_q, dy_d;
    logic                 sx_neg_q, sx_neg_d, sy_neg_q, sy_neg_d;

    // Pixel stage between the step logic and the address multiply.
    logic               pix_vld_q;
    logic [COORD_W-1:0] pix_x_q, pix_y_q;
    logic [COLOR_W-1:0] pix_col_q;
    logic [ADDR_W-1:0]  pix_addr;

    logic [ADDR_W-1:0]  addr_q;
    logic [COLOR_W-1:0] data_q;
    logic               wr_q, done_q;

    logic               accept, emit, in_bounds, at_end, step_x, step_y;
    logic [COORD_W-1:0] adx, ady;
    logic signed [EW:0] e2, dx_e, dy_e;

    assign O_CMD_READY = (state_q == ST_IDLE) && !I_RST;
    assign accept      = I_CMD_VALID && O_CMD_READY;
    assign O_BUSY      = (state_q == ST_SETUP) || (state_q == ST_DRAW);
    assign O_GPU_READ  = 1'b0;
    assign O_GPU_ADDR  = addr_q;
    assign O_GPU_DATA  = data_q;
    assign O_GPU_WRITE = wr_q;
    assign O_DONE      = done_q;

    // Step decisions and clipping test for the current point.
    always_comb begin
        adx       = (x1_q >= x0_q) ? (x1_q - x0_q) : (x0_q - x1_q);
        ady       = (y1_q >= y0_q) ? (y1_q - y0_q) : (y0_q - y1_q);
        e2        = {err_q, 1'b0};
        dx_e      = {dx_q[EW-1], dx_q};
        dy_e      = {dy_q[EW-1], dy_q};
        step_x    = (e2 >= dy_e);
        step_y    = (e2 <= dx_e);
        at_end    = (cx_q == x1_q) && (cy_q == y1_q);
        in_bounds = ({1'b0, cx_q} < FBW_C) && ({1'b0, cy_q} < FBH_C);
    end

    // Next-state and Bresenham step; a high I_VIDEO_ON freezes the walk.
    always_comb begin
        state_d  = state_q;
        cx_d     = cx_q;
        cy_d     = cy_q;
        err_d    = err_q;
        dx_d     = dx_q;
        dy_d     = dy_q;
        sx_neg_d = sx_neg_q;
        sy_neg_d = sy_neg_q;
        emit     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept) state_d = ST_SETUP;
            end
            ST_SETUP: begin
                dx_d     = $signed({2'b00, adx});
                dy_d     = -$signed({2'b00, ady});
                err_d    = $signed({2'b00, adx}) - $signed({2'b00, ady});
                sx_neg_d = (x1_q < x0_q);
                sy_neg_d = (y1_q < y0_q);
                cx_d     = x0_q;
                cy_d     = y0_q;
                state_d  = ST_DRAW;
            end
            ST_DRAW: begin
                if (!I_VIDEO_ON) begin
                    emit = 1'b1;
                    if (at_end) begin
                        state_d = ST_DONE;
                    end else begin
                        err_d = err_q + (step_x ? dy_q : '0) + (step_y ? dx_q : '0);
                        if (step_x) cx_d = sx_neg_q ? cx_q - 1'b1 : cx_q + 1'b1;
                        if (step_y) cy_d = sy_neg_q ? cy_q - 1'b1 : cy_q + 1'b1;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM and walk state registers.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            state_q  <= ST_IDLE;
            cx_q     <= '0;
            cy_q     <= '0;
            err_q    <= '0;
            dx_q     <= '0;
            dy_q     <= '0;
            sx_neg_q <= 1'b0;
            sy_neg_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cx_q     <= cx_d;
            cy_q     <= cy_d;
            err_q    <= err_d;
            dx_q     <= dx_d;
            dy_q     <= dy_d;
            sx_neg_q <= sx_neg_d;
            sy_neg_q <= sy_neg_d;
        end
    end

    // Command latch on handshake; held for the whole line.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            color_q <= '0;
        end else if (accept) begin
            x0_q    <= I_X0;
            y0_q    <= I_Y0;
            x1_q    <= I_X1;
            y1_q    <= I_Y1;
            color_q <= I_COLOR;
        end
    end

    fb_addr_gen #(
        .COORD_W  (COORD_W),
        .FB_WIDTH (FB_WIDTH),
        .ADDR_W   (ADDR_W)
    ) u_addr (
        .x_i    (pix_x_q),
        .y_i    (pix_y_q),
        .addr_o (pix_addr)
    );

    // Two-stage write pipeline; colour travels with the pixel so a new command
    // cannot recolour a pixel still held by a video stall.
    always_ff @(posedge I_CLK) begin
        if (I_RST) begin
            pix_vld_q <= 1'b0;
            pix_x_q   <= '0;
            pix_y_q   <= '0;
            pix_col_q <= '0;
            wr_q      <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
        end else if (!I_VIDEO_ON) begin
            pix_vld_q <= emit && in_bounds;
            pix_x_q   <= cx_q;
            pix_y_q   <= cy_q;
            pix_col_q <= color_q;
            wr_q      <= pix_vld_q;
            addr_q    <= pix_addr;
            data_q    <= pix_col_q;
        end else begin
            wr_q      <= 1'b0;
        end
    end

    // Completion pulse, one cycle after the DONE state.
    always_ff @(posedge I_CLK) begin
        if (I_RST) done_q <= 1'b0;
        else       done_q <= (state_q == ST_DONE);
    end

endmodule

// File: tb/tb_line_raster.sv
module tb_line_raster;

    logic        clk = 1'b0;
    logic        rst, vld, vo;
    logic [9:0]  x0, y0, x1, y1;
    logic [15:0] col;
    logic        rdy, wr, rd, busy, done;
    logic [17:0] addr;
    logic [15:0] data;

    line_raster dut (
        .I_CLK       (clk),
        .I_RST       (rst),
        .I_CMD_VALID (vld),
        .O_CMD_READY (rdy),
        .I_X0        (x0),
        .I_Y0        (y0),
        .I_X1        (x1),
        .I_Y1        (y1),
        .I_COLOR     (col),
        .I_VIDEO_ON  (vo),
        .O_GPU_ADDR  (addr),
        .O_GPU_DATA  (data),
        .O_GPU_WRITE (wr),
        .O_GPU_READ  (rd),
        .O_BUSY      (busy),
        .O_DONE      (done)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int accept_cyc = 0;
    bit first_pending = 1'b0;
    logic vo_q = 1'b0;
    logic [33:0] exp_q[$];

    always @(posedge clk) begin
        cyc  <= cyc + 1;
        vo_q <= vo;
    end

    // Monitor: every write strobe is checked against the scoreboard queue.
    always @(negedge clk) begin
        logic [33:0] e;
        if (!rst && wr) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, expected no write", addr, data);
            end else begin
                e = exp_q.pop_front();
                if ({addr, data} !== e)
                    begin
                        fails++;
                        $display("FAIL write_seq: got addr=%0d data=%h, expected addr=%0d data=%h",
                                 addr, data, e[33:16], e[15:0]);
                    end
            end
            tests++;
            if (vo_q) begin
                fails++;
                $display("FAIL write_during_video: got strobe=1 after video-on edge, expected 0");
            end
            if (first_pending) begin
                first_pending = 1'b0;
                tests++;
                if (cyc != accept_cyc + 3) begin
                    fails++;
                    $display("FAIL first_write_latency: got edge %0d, expected edge %0d", cyc, accept_cyc + 3);
                end
            end
            wr_cnt++;
        end
        if (!rst && done) done_cnt++;
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic push(input int a, input logic [15:0] c);
        exp_q.push_back({18'(a), c});
    endtask

    task automatic send(input int ax0, input int ay0, input int ax1, input int ay1);
        int n = 0;
        x0 = 10'(ax0); y0 = 10'(ay0); x1 = 10'(ax1); y1 = 10'(ay1);
        vld = 1'b1;
        while (!rdy && n < 100) begin
            tick();
            n++;
        end
        if (!rdy) begin
            fails++;
            tests++;
            $display("FAIL send_timeout: got ready=0, expected 1");
            vld = 1'b0;
        end else begin
            first_pending = 1'b1;
            @(posedge clk);
            #1;
            accept_cyc = cyc;
            vld = 1'b0;
        end
    endtask

    task automatic wait_done(input int target);
        int n = 0;
        while (done_cnt < target && n < 400) begin
            tick();
            n++;
        end
        check("done_pulse", 64'(done_cnt), 64'(target));
        tick();
        tick();
        check("writes_complete", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        int base, d0, n;
        rst = 1'b1; vld = 1'b0; vo = 1'b0;
        x0 = '0; y0 = '0; x1 = '0; y1 = '0; col = '0;
        tick(); tick(); tick();
        check("rst_write", 64'(wr), 64'd0);
        check("rst_addr",  64'(addr), 64'd0);
        check("rst_data",  64'(data), 64'd0);
        check("rst_read",  64'(rd), 64'd0);
        check("rst_done",  64'(done), 64'd0);
        check("rst_busy",  64'(busy), 64'd0);
        check("rst_ready", 64'(rdy), 64'd0);
        rst = 1'b0;
        tick();
        check("idle_ready", 64'(rdy), 64'd1);

        // Horizontal line.
        col = 16'h1111;
        for (int i = 0; i < 5; i++) push(i, col);
        send(0, 0, 4, 0);
        tick();
        check("busy_in_line", 64'(busy), 64'd1);
        check("ready_in_line", 64'(rdy), 64'd0);
        wait_done(1);

        // Shallow line drawn right-to-left, bottom-to-top.
        col = 16'h2222;
        push(1284, col); push(643, col); push(642, col); push(1, col); push(0, col);
        send(4, 2, 0, 0);
        wait_done(2);

        // Steep line.
        col = 16'h3333;
        push(6410, col); push(7050, col); push(7691, col);
        push(8331, col); push(8972, col); push(9612, col);
        send(10, 10, 12, 15);
        wait_done(3);

        // Video-on stall after the second pixel.
        col = 16'h4444;
        for (int i = 0; i < 5; i++) push(i, col);
        base = wr_cnt;
        send(0, 0, 4, 0);
        n = 0;
        while (wr_cnt < base + 2 && n < 50) begin
            tick();
            n++;
        end
        check("video_pre_writes", 64'(wr_cnt - base), 64'd2);
        vo = 1'b1;
        tick(); tick(); tick();
        check("video_hold", 64'(wr_cnt - base), 64'd2);
        vo = 1'b0;
        wait_done(4);

        // Vertical line crossing the bottom edge; a command while busy is ignored.
        col = 16'h5555;
        push(254720, col); push(255360, col);
        send(0, 398, 0, 401);
        tick(); tick();
        x0 = 10'd7; y0 = 10'd7; x1 = 10'd9; y1 = 10'd9;
        vld = 1'b1;
        for (int i = 0; i < 3; i++) begin
            check("ready_while_busy", 64'(rdy), 64'd0);
            tick();
        end
        vld = 1'b0;
        wait_done(5);
        for (int i = 0; i < 5; i++) tick();
        check("single_done", 64'(done_cnt), 64'd5);

        // Reset in the middle of a long line.
        col = 16'h6666;
        for (int i = 0; i <= 100; i++) push(i, col);
        base = wr_cnt;
        send(0, 0, 100, 0);
        n = 0;
        while (wr_cnt < base + 5 && n < 50) begin
            tick();
            n++;
        end
        check("pre_reset_writes", 64'(wr_cnt - base >= 5), 64'd1);
        rst = 1'b1;
        exp_q.delete();
        d0 = done_cnt;
        tick();
        check("abort_write", 64'(wr), 64'd0);
        check("abort_busy",  64'(busy), 64'd0);
        check("abort_ready", 64'(rdy), 64'd0);
        rst = 1'b0;
        tick();
        check("ready_after_reset", 64'(rdy), 64'd1);
        for (int i = 0; i < 5; i++) tick();
        check("no_done_after_abort", 64'(done_cnt), 64'(d0));

        // Single-point line.
        col = 16'h7777;
        push(3205, col);
        send(5, 5, 5, 5);
        wait_done(d0 + 1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
